// File: rtl/mm_read_client.sv
// mm_read_client: per-requester read front-end for one multimemory read port.
// Tagged cmds in, r_addr/r_avalid issue, in-order r_dvalid returns paired with
// tags into a registered, back-pressurable response channel. Credits cap reads
// in flight plus buffered at DEPTH because the return path cannot stall.
// Ports: clk, rst (async, active-high)
//   cmd_valid/cmd_ready/cmd_addr/cmd_tag : command channel
//   r_addr/r_avalid/r_aready             : memory address handshake
//   r_dvalid/r_data                      : memory data return
//   rsp_valid/rsp_ready/rsp_data/rsp_tag : response channel
//   outstanding                          : reserved slots
//   err_unexpected                       : sticky spurious-return flag
module mm_read_client #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [TAG_WIDTH-1:0]     cmd_tag,
  output logic [ADDR_WIDTH-1:0]    r_addr,
  output logic                     r_avalid,
  input  logic                     r_aready,
  input  logic                     r_dvalid,
  input  logic [DATA_WIDTH-1:0]    r_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexpected
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = TAG_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  avalid_q, avalid_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         iss_q, iss_d;
  logic                  err_q, err_d;
  logic [PW:0]           tag_wp_q, tag_wp_d;
  logic [PW:0]           tag_rp_q, tag_rp_d;
  logic [PW:0]           rf_wp_q, rf_wp_d;
  logic [PW:0]           rf_rp_q, rf_rp_d;
  logic                  rvld_q, rvld_d;
  logic [RW-1:0]         rsp_q, rsp_d;

  logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];
  logic [RW-1:0]         rf_mem  [DEPTH];

  logic accept, hs, ret_ok, rsp_hs;
  logic load, rf_empty, rf_push, rf_pop;
  logic [RW-1:0] ret_word;

  assign cmd_ready = (out_q < DEPTH_C) && (!avalid_q || r_aready);
  assign accept    = cmd_valid && cmd_ready;
  assign hs        = avalid_q && r_aready;
  // A return only counts against reads already issued; a same-cycle
  // address handshake cannot be answered yet.
  assign ret_ok    = r_dvalid && (iss_q != '0);
  assign rsp_hs    = rvld_q && rsp_ready;
  assign load      = !rvld_q || rsp_ready;
  assign rf_empty  = (rf_wp_q == rf_rp_q);
  assign ret_word  = {tag_mem[tag_rp_q[PW-1:0]], r_data};
  // Output register takes a return directly when nothing is queued ahead.
  assign rf_pop    = load && !rf_empty;
  assign rf_push   = ret_ok && !(load && rf_empty);

  always_comb begin
    addr_d   = addr_q;
    avalid_d = avalid_q;
    if (accept) begin
      addr_d   = cmd_addr;
      avalid_d = 1'b1;
    end else if (hs) begin
      avalid_d = 1'b0;
    end
    out_d    = out_q + CW'(accept) - CW'(rsp_hs);
    iss_d    = iss_q + CW'(hs) - CW'(ret_ok);
    err_d    = err_q || (r_dvalid && (iss_q == '0));
    tag_wp_d = tag_wp_q + (PW+1)'(accept);
    tag_rp_d = tag_rp_q + (PW+1)'(ret_ok);
    rf_wp_d  = rf_wp_q + (PW+1)'(rf_push);
    rf_rp_d  = rf_rp_q + (PW+1)'(rf_pop);
    rvld_d   = rvld_q;
    rsp_d    = rsp_q;
    if (load) begin
      if (!rf_empty) begin
        rvld_d = 1'b1;
        rsp_d  = rf_mem[rf_rp_q[PW-1:0]];
      end else if (ret_ok) begin
        rvld_d = 1'b1;
        rsp_d  = ret_word;
      end else begin
        rvld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      avalid_q <= 1'b0;
      out_q    <= '0;
      iss_q    <= '0;
      err_q    <= 1'b0;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      rf_wp_q  <= '0;
      rf_rp_q  <= '0;
      rvld_q   <= 1'b0;
      rsp_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      avalid_q <= avalid_d;
      out_q    <= out_d;
      iss_q    <= iss_d;
      err_q    <= err_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      rf_wp_q  <= rf_wp_d;
      rf_rp_q  <= rf_rp_d;
      rvld_q   <= rvld_d;
      rsp_q    <= rsp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wp_q[PW-1:0]] <= cmd_tag;
    if (rf_push)
      rf_mem[rf_wp_q[PW-1:0]] <= ret_word;
  end

  assign r_addr         = addr_q;
  assign r_avalid       = avalid_q;
  assign rsp_valid      = rvld_q;
  assign rsp_data       = rsp_q[DATA_WIDTH-1:0];
  assign rsp_tag        = rsp_q[RW-1:DATA_WIDTH];
  assign outstanding    = out_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_mm_read_client.sv
// tb_mm_read_client: directed + random checks of mm_read_client against a
// queue-based scoreboard and an in-order variable-latency memory model.
module tb_mm_read_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_tag;
  logic [15:0] r_addr;
  logic        r_avalid, r_aready;
  logic        r_dvalid;
  logic [15:0] r_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [2:0]  outstanding;
  logic        err_unexpected;

  logic        mem_dv, spur;
  logic [15:0] mem_dd, spur_d;
  logic [15:0] mem [0:255];

  int n_chk = 0;
  int n_fail = 0;
  int fixed_lat = 1;
  int cyc = 0;
  int hs_cnt = 0;
  int n_deliv = 0;

  assign r_dvalid = mem_dv | spur;
  assign r_data   = spur ? spur_d : mem_dd;

  mm_read_client #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .TAG_WIDTH(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
    .r_dvalid(r_dvalid), .r_data(r_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tg, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: records handshakes, answers strictly in order after 1..4 cycles.
  typedef struct { int due; logic [15:0] d; } ret_t;
  ret_t rq[$];
  int   last_due = 0;

  always begin
    @(negedge clk);
    if (rst) begin
      rq.delete();
      last_due = 0;
    end else if (r_avalid && r_aready) begin
      int lat;
      int due;
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{due, mem[r_addr[7:0]]});
      hs_cnt++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      mem_dv = 1'b1;
      mem_dd = rq[0].d;
      void'(rq.pop_front());
    end else begin
      mem_dv = 1'b0;
    end
  end

  // Scoreboard: responses must come back in acceptance order.
  typedef struct { logic [3:0] tag; logic [15:0] d; } exp_t;
  exp_t        eq[$];
  logic        hold_q = 1'b0;
  logic [15:0] hold_d;
  logic [3:0]  hold_t;

  always @(negedge clk) begin
    if (rst) begin
      eq.delete();
      hold_q = 1'b0;
    end else begin
      check("outstanding", 32'(outstanding), eq.size());
      check("out_le_depth", 32'(outstanding <= 3'd4), 1);
      if (hold_q) begin
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_data", 32'(rsp_data), 32'(hold_d));
        check("hold_tag", 32'(rsp_tag), 32'(hold_t));
      end
      hold_q = rsp_valid && !rsp_ready;
      hold_d = rsp_data;
      hold_t = rsp_tag;
      if (rsp_valid && rsp_ready) begin
        if (eq.size() == 0) begin
          check("rsp_extra", 32'(rsp_valid), 0);
        end else begin
          exp_t e;
          e = eq.pop_front();
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check("rsp_data", 32'(rsp_data), 32'(e.d));
          n_deliv++;
        end
      end
      if (cmd_valid && cmd_ready)
        eq.push_back('{cmd_tag, mem[cmd_addr[7:0]]});
    end
  end

  task automatic send(input logic [15:0] a, input logic [3:0] t,
                      input bit rnd);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_tag   = t;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (rnd) begin
        r_aready  = ($urandom_range(0, 3) != 0);
        rsp_ready = $urandom_range(0, 1) != 0;
      end
      #1;
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic drain(input string tg);
    for (int k = 0; k < 100; k++) begin
      if (outstanding == 3'd0 && !r_avalid) break;
      tick();
    end
    check(tg, 32'(outstanding), 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int base, h0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_tag = '0;
    r_aready = 1'b0;
    rsp_ready = 1'b0;
    mem_dv = 1'b0;
    mem_dd = '0;
    spur = 1'b0;
    spur_d = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);

    // Reset state, then a mid-cycle reset with a command pending.
    tick();
    tick();
    check("rst_avalid", 32'(r_avalid), 0);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_out", 32'(outstanding), 0);
    rst = 1'b0;
    send(16'h0055, 4'd7, 1'b0);
    check("t1_avalid", 32'(r_avalid), 1);
    check("t1_addr", 32'(r_addr), 32'h55);
    pulse_rst();
    check("t1_rst_avalid", 32'(r_avalid), 0);
    check("t1_rst_addr", 32'(r_addr), 0);
    check("t1_rst_out", 32'(outstanding), 0);
    check("t1_rst_rspv", 32'(rsp_valid), 0);
    check("t1_rst_data", 32'(rsp_data), 0);
    check("t1_rst_tag", 32'(rsp_tag), 0);
    check("t1_rst_err", 32'(err_unexpected), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t1_ready", 32'(cmd_ready), 1);
    check("t1_out", 32'(outstanding), 0);

    // Single read, memory latency 2.
    r_aready = 1'b1;
    rsp_ready = 1'b1;
    fixed_lat = 2;
    send(16'h0010, 4'd3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (r_dvalid) break;
      tick();
    end
    check("t2_dvalid", 32'(r_dvalid), 1);
    check("t2_early", 32'(rsp_valid), 0);
    tick();
    check("t2_rspv", 32'(rsp_valid), 1);
    check("t2_data", 32'(rsp_data), 32'h10);
    check("t2_tag", 32'(rsp_tag), 3);
    tick();
    check("t2_idle", 32'(rsp_valid), 0);
    check("t2_out", 32'(outstanding), 0);

    // Credit limit: four fill the buffer, fifth waits for a drain.
    rsp_ready = 1'b0;
    fixed_lat = 1;
    for (int i = 0; i < 4; i++) send(16'h0020 + 16'(i), 4'(i), 1'b0);
    repeat (8) tick();
    check("t3_out4", 32'(outstanding), 4);
    cmd_valid = 1'b1;
    cmd_addr = 16'h0024;
    cmd_tag = 4'd4;
    #1;
    check("t3_full", 32'(cmd_ready), 0);
    check("t3_head", 32'(rsp_tag), 0);
    tick();
    #1;
    check("t3_full2", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    #1;
    check("t3_full3", 32'(cmd_ready), 0);
    tick();
    #1;
    check("t3_out3", 32'(outstanding), 3);
    check("t3_ready", 32'(cmd_ready), 1);
    check("t3_tag1", 32'(rsp_tag), 1);
    tick();
    cmd_valid = 1'b0;
    check("t3_out3b", 32'(outstanding), 3);
    check("t3_tag2", 32'(rsp_tag), 2);
    drain("t3_drain");

    // Address stall: r_addr and r_avalid hold, one handshake on release.
    r_aready = 1'b0;
    send(16'h0011, 4'd5, 1'b0);
    h0 = hs_cnt;
    cmd_valid = 1'b1;
    cmd_addr = 16'h0033;
    cmd_tag = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_avalid", 32'(r_avalid), 1);
      check("t4_addr", 32'(r_addr), 32'h11);
      check("t4_ready", 32'(cmd_ready), 0);
      tick();
    end
    cmd_valid = 1'b0;
    r_aready = 1'b1;
    tick();
    check("t4_drop", 32'(r_avalid), 0);
    check("t4_hs1", hs_cnt - h0, 1);
    tick();
    check("t4_hs1b", hs_cnt - h0, 1);
    drain("t4_drain");

    // Spurious return with nothing issued.
    check("t5_pre_err", 32'(err_unexpected), 0);
    spur_d = 16'hBEEF;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    check("t5_err", 32'(err_unexpected), 1);
    check("t5_rspv", 32'(rsp_valid), 0);
    check("t5_out", 32'(outstanding), 0);
    repeat (3) tick();
    check("t5_err_sticky", 32'(err_unexpected), 1);
    check("t5_rspv2", 32'(rsp_valid), 0);
    pulse_rst();
    check("t5_err_clr", 32'(err_unexpected), 0);
    tick();
    tick();
    rst = 1'b0;

    // Random stream against the scoreboard.
    fixed_lat = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    base = n_deliv;
    h0 = hs_cnt;
    for (int n = 0; n < 200; n++) begin
      send(16'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = $urandom_range(0, 1) != 0;
        tick();
      end
    end
    r_aready = 1'b1;
    rsp_ready = 1'b1;
    drain("t6_drain");
    tick();
    check("t6_deliv", n_deliv - base, 200);
    check("t6_issued", hs_cnt - h0, 200);
    check("t6_err", 32'(err_unexpected), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
